// File: rtl/jtkcpu_stk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtkcpu_stk_pkg
//  Purpose  : Shared constants for the KONAMI CPU stack push/pull sequencer:
//             FSM state encoding, transfer direction codes, default
//             wide-register mask and standard register index numbers.
//  Ports    : none (package)
//  Revision : 1.0  initial parametrised sequencer release
// ============================================================================
package jtkcpu_stk_pkg;

  // Sequencer FSM encoding
  localparam int                ST_W    = 2;
  localparam logic [ST_W-1:0]   ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0]   ST_XFER = 2'd1;
  localparam logic [ST_W-1:0]   ST_FIN  = 2'd2;

  // Transfer direction
  localparam logic PSH = 1'b0;
  localparam logic PUL = 1'b1;

  // Default register set: X, Y, U/S and PC are 16-bit
  localparam logic [7:0] WIDE_DEF = 8'hF0;

  // Standard register indices (mask bit positions)
  localparam int REG_CC = 0;
  localparam int REG_A  = 1;
  localparam int REG_B  = 2;
  localparam int REG_DP = 3;
  localparam int REG_X  = 4;
  localparam int REG_Y  = 5;
  localparam int REG_US = 6;
  localparam int REG_PC = 7;

endpackage
`default_nettype wire

// File: rtl/jtkcpu_prienc.sv
`default_nettype none
// ============================================================================
//  Module   : jtkcpu_prienc
//  Purpose  : MW-bit priority encoder with selectable search direction.
//  Ports    : req   - request bit vector
//             dir   - 0: highest set bit wins, 1: lowest set bit wins
//             idx   - index of the winning bit (0 when nothing is set)
//             valid - at least one request bit is set
//  Revision : 1.0  initial release
// ============================================================================
module jtkcpu_prienc #(
  parameter int MW = 8,
  parameter int IW = 3
) (
  input  logic [MW-1:0] req,
  input  logic          dir,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // The loops run so that the preferred bit is visited last and overrides
  // any earlier match.
  always_comb begin
    idx = '0;
    if (dir) begin
      for (int i = MW - 1; i >= 0; i--) begin
        if (req[i]) idx = IW'(i);
      end
    end else begin
      for (int i = 0; i < MW; i++) begin
        if (req[i]) idx = IW'(i);
      end
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/jtkcpu_stkseq.sv
`default_nettype none
// ============================================================================
//  Module   : jtkcpu_stkseq
//  Purpose  : Stack push/pull sequencer. Turns a register mask into an
//             ordered run of single-byte stack transfers with bus wait
//             states, abort, completion pulse and a byte counter.
//  Ports    : rst      - asynchronous reset, active high
//             clk      - clock
//             cen      - clock enable; all state advances only on cen
//             start    - request (sampled only when idle)
//             dir      - 0 push, 1 pull (latched with start)
//             mask     - registers to transfer (latched with start)
//             us_req   - stack select 0 S / 1 U (latched with start)
//             bus_rdy  - bus accepts/returns the current byte
//             abort    - cancel the running sequence
//             busy     - sequence in progress
//             idx      - register currently addressed
//             hihalf   - current byte is the high byte of a 16-bit register
//             wr / rd  - push / pull byte strobes
//             sp_step  - stack pointer adjusts this cycle
//             us_sel   - latched stack select
//             done     - one-cen-cycle pulse on normal completion
//             bytes    - bytes transferred in the current/last sequence
//  Revision : 1.0  initial parametrised release
// ============================================================================
module jtkcpu_stkseq
  import jtkcpu_stk_pkg::*;
#(
  parameter int            MW   = 8,
  parameter logic [MW-1:0] WIDE = WIDE_DEF,
  parameter int            IW   = 3,
  parameter int            CW   = 5
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          start,
  input  logic          dir,
  input  logic [MW-1:0] mask,
  input  logic          us_req,
  input  logic          bus_rdy,
  input  logic          abort,
  output logic          busy,
  output logic [IW-1:0] idx,
  output logic          hihalf,
  output logic          wr,
  output logic          rd,
  output logic          sp_step,
  output logic          us_sel,
  output logic          done,
  output logic [CW-1:0] bytes
);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;

  logic [MW-1:0]   pend;       // registers still to be transferred
  logic            dir_l;      // latched direction
  logic            us_l;       // latched stack select
  logic            second;     // current register is on its second byte

  logic [IW-1:0]   enc_idx;
  logic            enc_vld;
  logic [MW-1:0]   cur_bit;
  logic [MW-1:0]   pend_nxt;
  logic            cur_wide;
  logic            half_step;
  logic            accept;
  logic            last_byte;

  jtkcpu_prienc #(
    .MW (MW),
    .IW (IW)
  ) u_prienc (
    .req   (pend),
    .dir   (dir_l),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  // One-hot of the addressed register; the wide test uses the one-hot so
  // no variable part-select of the parameter is needed.
  assign cur_bit   = MW'(1) << enc_idx;
  assign cur_wide  = |(WIDE & cur_bit);
  assign pend_nxt  = pend & ~cur_bit;
  assign half_step = cur_wide & ~second;
  assign accept    = (state == ST_XFER) & bus_rdy & ~abort & enc_vld;
  assign last_byte = ~half_step & (pend_nxt == '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (cen) begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start & ~abort) begin
          state_nxt = (mask != '0) ? ST_XFER : ST_FIN;
        end
      end
      ST_XFER: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (accept & last_byte) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_XFER: busy = 1'b1;
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
    wr      = busy & ~dir_l;
    rd      = busy &  dir_l;
    sp_step = (wr | rd) & bus_rdy & cen;
    // Push sends the low byte first, pull the high byte first: the
    // direction simply flips the meaning of the second-byte flag.
    hihalf  = busy & cur_wide & (second ^ dir_l);
    idx     = enc_idx;
  end

  assign us_sel = us_l;

  // --------------------------------------------------------------------------
  // Sequence datapath: pending mask, latched request fields, byte counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= '0;
      dir_l  <= 1'b0;
      us_l   <= 1'b0;
      second <= 1'b0;
      bytes  <= '0;
    end else if (cen) begin
      if (abort) begin
        // bytes deliberately keeps the partial count
        pend   <= '0;
        second <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              pend   <= mask;
              dir_l  <= dir;
              us_l   <= us_req;
              second <= 1'b0;
              bytes  <= '0;
            end
          end
          ST_XFER: begin
            if (accept) begin
              bytes <= bytes + CW'(1);
              if (half_step) begin
                second <= 1'b1;
              end else begin
                second <= 1'b0;
                pend   <= pend_nxt;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_stkseq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_jtkcpu_stkseq
//  Purpose  : Self-checking bench for the stack push/pull sequencer. The
//             expected byte order is built from the register mask with a
//             simple list model and compared cycle by cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtkcpu_stkseq;
  import jtkcpu_stk_pkg::*;

  localparam int         MW     = 8;
  localparam int         IW     = 3;
  localparam int         CW     = 5;
  localparam logic [7:0] WIDE_M = 8'hF0;

  logic          rst, clk, cen, start, dir, us_req, bus_rdy, abort;
  logic [MW-1:0] mask;
  logic          busy, hihalf, wr, rd, sp_step, us_sel, done;
  logic [IW-1:0] idx;
  logic [CW-1:0] bytes;

  int checks = 0;
  int errors = 0;

  // Expected transfer list: (register index, high-half flag) per byte
  int exp_idx[$];
  bit exp_hi[$];

  jtkcpu_stkseq #(
    .MW   (MW),
    .WIDE (WIDE_M),
    .IW   (IW),
    .CW   (CW)
  ) dut (
    .rst     (rst),
    .clk     (clk),
    .cen     (cen),
    .start   (start),
    .dir     (dir),
    .mask    (mask),
    .us_req  (us_req),
    .bus_rdy (bus_rdy),
    .abort   (abort),
    .busy    (busy),
    .idx     (idx),
    .hihalf  (hihalf),
    .wr      (wr),
    .rd      (rd),
    .sp_step (sp_step),
    .us_sel  (us_sel),
    .done    (done),
    .bytes   (bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push: registers high to low, each wide one low byte then high byte.
  // Pull: registers low to high, each wide one high byte then low byte.
  function automatic void build_exp(input bit d, input logic [7:0] m);
    exp_idx.delete();
    exp_hi.delete();
    for (int s = 0; s < MW; s++) begin
      int r;
      r = d ? s : (MW - 1 - s);
      if (m[r]) begin
        if (WIDE_M[r]) begin
          exp_idx.push_back(r); exp_hi.push_back(d);
          exp_idx.push_back(r); exp_hi.push_back(!d);
        end else begin
          exp_idx.push_back(r); exp_hi.push_back(1'b0);
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start for one cen edge, then scramble the request inputs so the
  // DUT must rely on its latched copies.
  task automatic do_start(input bit d, input logic [7:0] m, input bit u);
    start  = 1'b1;
    dir    = d;
    mask   = m;
    us_req = u;
    tick();
    start  = 1'b0;
    dir    = 1'($urandom);
    mask   = 8'($urandom);
    us_req = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; start = 1'b0; dir = 1'b0; mask = '0;
    us_req = 1'b0; bus_rdy = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, idx, hihalf, wr, rd, sp_step, us_sel, done, bytes} !== '0) begin
      errors++;
      $display("FAIL reset_held: busy=%b idx=%0d hi=%b wr=%b rd=%b step=%b us=%b done=%b bytes=%0d required all 0",
               busy, idx, hihalf, wr, rd, sp_step, us_sel, done, bytes);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, wr, rd, done, bytes} !== '0) begin
      errors++;
      $display("FAIL reset_release: busy=%b wr=%b rd=%b done=%b bytes=%0d required all 0",
               busy, wr, rd, done, bytes);
    end
  endtask

  task automatic test_push_all();
    int n;
    build_exp(PSH, 8'hFF);
    n = exp_idx.size();
    bus_rdy = 1'b1;
    do_start(PSH, 8'hFF, 1'b0);
    for (int k = 0; k < n; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || wr !== 1'b1 || rd !== 1'b0 || idx !== 3'(exp_idx[k]) ||
          hihalf !== exp_hi[k] || sp_step !== 1'b1 || done !== 1'b0 || bytes !== 5'(k)) begin
        errors++;
        $display("FAIL push_all byte %0d: busy=%b wr=%b rd=%b idx=%0d hi=%b step=%b done=%b bytes=%0d required idx=%0d hi=%b bytes=%0d",
                 k, busy, wr, rd, idx, hihalf, sp_step, done, bytes, exp_idx[k], exp_hi[k], k);
      end
      tick();
    end
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr !== 1'b0 || bytes !== 5'd12) begin
      errors++;
      $display("FAIL push_all_done: done=%b busy=%b wr=%b bytes=%0d required done=1 busy=0 wr=0 bytes=12",
               done, busy, wr, bytes);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bytes !== 5'd12) begin
      errors++;
      $display("FAIL push_all_after: done=%b busy=%b bytes=%0d required done=0 busy=0 bytes=12",
               done, busy, bytes);
    end
  endtask

  task automatic test_pull_81();
    int n;
    build_exp(PUL, 8'h81);
    n = exp_idx.size();
    bus_rdy = 1'b1;
    do_start(PUL, 8'h81, 1'b1);
    for (int k = 0; k < n; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || rd !== 1'b1 || wr !== 1'b0 || idx !== 3'(exp_idx[k]) ||
          hihalf !== exp_hi[k] || us_sel !== 1'b1 || sp_step !== 1'b1 || bytes !== 5'(k)) begin
        errors++;
        $display("FAIL pull_81 byte %0d: busy=%b rd=%b wr=%b idx=%0d hi=%b us=%b step=%b bytes=%0d required idx=%0d hi=%b us=1 bytes=%0d",
                 k, busy, rd, wr, idx, hihalf, us_sel, sp_step, bytes, exp_idx[k], exp_hi[k], k);
      end
      tick();
    end
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rd !== 1'b0 || bytes !== 5'd3) begin
      errors++;
      $display("FAIL pull_81_done: done=%b busy=%b rd=%b bytes=%0d required done=1 busy=0 rd=0 bytes=3",
               done, busy, rd, bytes);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL pull_81_single_done: done=%b required 0", done);
    end
  endtask

  task automatic test_wait_states();
    bit rdy_pat[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int k;
    k = 0;
    build_exp(PSH, 8'h10);
    do_start(PSH, 8'h10, 1'b0);
    for (int c = 0; c < 4; c++) begin
      bus_rdy = rdy_pat[c];
      #1;
      checks++;
      if (busy !== 1'b1 || wr !== 1'b1 || idx !== 3'(exp_idx[k]) || hihalf !== exp_hi[k] ||
          sp_step !== rdy_pat[c] || bytes !== 5'(k)) begin
        errors++;
        $display("FAIL wait cycle %0d: busy=%b wr=%b idx=%0d hi=%b step=%b bytes=%0d required idx=%0d hi=%b step=%b bytes=%0d",
                 c, busy, wr, idx, hihalf, sp_step, bytes, exp_idx[k], exp_hi[k], rdy_pat[c], k);
      end
      if (rdy_pat[c]) k++;
      tick();
    end
    bus_rdy = 1'b1;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bytes !== 5'd2) begin
      errors++;
      $display("FAIL wait_done: done=%b busy=%b bytes=%0d required done=1 busy=0 bytes=2",
               done, busy, bytes);
    end
    tick();
  endtask

  task automatic test_zero_mask();
    bus_rdy = 1'b1;
    do_start(PSH, 8'h00, 1'b0);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr !== 1'b0 || rd !== 1'b0 || sp_step !== 1'b0 || bytes !== 5'd0) begin
      errors++;
      $display("FAIL zero_mask: done=%b busy=%b wr=%b rd=%b step=%b bytes=%0d required done=1 others 0",
               done, busy, wr, rd, sp_step, bytes);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_mask_after: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    build_exp(PUL, 8'hFE);
    bus_rdy = 1'b1;
    do_start(PUL, 8'hFE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || rd !== 1'b1 || idx !== 3'(exp_idx[k]) || hihalf !== exp_hi[k] || bytes !== 5'(k)) begin
        errors++;
        $display("FAIL abort_pre byte %0d: busy=%b rd=%b idx=%0d hi=%b bytes=%0d required idx=%0d hi=%b bytes=%0d",
                 k, busy, rd, idx, hihalf, bytes, exp_idx[k], exp_hi[k], k);
      end
      tick();
    end
    abort   = 1'b1;
    bus_rdy = 1'b0;
    start   = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || idx !== 3'(exp_idx[4]) || hihalf !== exp_hi[4]) begin
      errors++;
      $display("FAIL abort_cycle: busy=%b idx=%0d hi=%b required busy=1 idx=%0d hi=%b",
               busy, idx, hihalf, exp_idx[4], exp_hi[4]);
    end
    tick();
    abort = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd !== 1'b0 || bytes !== 5'd4 || idx !== 3'd0) begin
      errors++;
      $display("FAIL abort_after: busy=%b done=%b rd=%b bytes=%0d idx=%0d required busy=0 done=0 rd=0 bytes=4 idx=0",
               busy, done, rd, bytes, idx);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%b busy=%b required 0 0", done, busy);
    end
    bus_rdy = 1'b1;
    do_start(PSH, 8'h01, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b1 || wr !== 1'b1 || idx !== 3'd0 || hihalf !== 1'b0 || bytes !== 5'd0) begin
      errors++;
      $display("FAIL abort_restart: busy=%b wr=%b idx=%0d hi=%b bytes=%0d required busy=1 wr=1 idx=0 hi=0 bytes=0",
               busy, wr, idx, hihalf, bytes);
    end
    tick();
    checks++;
    if (done !== 1'b1 || bytes !== 5'd1) begin
      errors++;
      $display("FAIL abort_restart_done: done=%b bytes=%0d required done=1 bytes=1", done, bytes);
    end
    tick();
  endtask

  task automatic test_cen_toggle();
    int k;
    int n;
    int c;
    build_exp(PSH, 8'h06);
    n = exp_idx.size();
    bus_rdy = 1'b1;
    cen = 1'b1;
    do_start(PSH, 8'h06, 1'b0);
    k = 0;
    c = 0;
    while (k < n && c < 20) begin
      cen = c[0];
      #1;
      checks++;
      if (busy !== 1'b1 || wr !== 1'b1 || idx !== 3'(exp_idx[k]) || hihalf !== exp_hi[k] ||
          sp_step !== cen || bytes !== 5'(k)) begin
        errors++;
        $display("FAIL cen_toggle cycle %0d: busy=%b wr=%b idx=%0d hi=%b step=%b bytes=%0d required idx=%0d hi=%b step=%b bytes=%0d",
                 c, busy, wr, idx, hihalf, sp_step, bytes, exp_idx[k], exp_hi[k], cen, k);
      end
      if (cen) k++;
      c++;
      tick();
    end
    cen = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bytes !== 5'd2) begin
      errors++;
      $display("FAIL cen_done: done=%b busy=%b bytes=%0d required done=1 busy=0 bytes=2", done, busy, bytes);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL cen_done_frozen: done=%b required 1 while cen low", done);
    end
    cen = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL cen_done_clear: done=%b required 0", done);
    end
    // Asynchronous reset in the middle of a sequence
    do_start(PUL, 8'hFF, 1'b1);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, idx, hihalf, wr, rd, sp_step, us_sel, done, bytes} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b idx=%0d hi=%b wr=%b rd=%b step=%b us=%b done=%b bytes=%0d required all 0",
               busy, idx, hihalf, wr, rd, sp_step, us_sel, done, bytes);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] m;
    bit d;
    bit u;
    int k;
    int budget;
    for (int it = 0; it < 25; it++) begin
      m = 8'($urandom);
      if (m == 8'h00) m = 8'h01;
      d = 1'($urandom);
      u = 1'($urandom);
      build_exp(d, m);
      do_start(d, m, u);
      k = 0;
      budget = 0;
      while (k < exp_idx.size() && budget < 200) begin
        bus_rdy = ($urandom_range(0, 3) != 0);
        start   = 1'($urandom);
        #1;
        checks++;
        if (busy !== 1'b1 || wr !== ~d || rd !== d || us_sel !== u || idx !== 3'(exp_idx[k]) ||
            hihalf !== exp_hi[k] || sp_step !== bus_rdy || bytes !== 5'(k) || done !== 1'b0) begin
          errors++;
          $display("FAIL random seq %0d byte %0d: busy=%b wr=%b rd=%b us=%b idx=%0d hi=%b step=%b bytes=%0d required dir=%b us=%b idx=%0d hi=%b bytes=%0d",
                   it, k, busy, wr, rd, us_sel, idx, hihalf, sp_step, bytes, d, u, exp_idx[k], exp_hi[k], k);
        end
        if (bus_rdy) k++;
        budget++;
        tick();
      end
      start = 1'b0;
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || wr !== 1'b0 || rd !== 1'b0 || bytes !== 5'(exp_idx.size())) begin
        errors++;
        $display("FAIL random seq %0d end: done=%b busy=%b wr=%b rd=%b bytes=%0d required done=1 busy=0 bytes=%0d",
                 it, done, busy, wr, rd, bytes, exp_idx.size());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_push_all();
    test_pull_81();
    test_wait_states();
    test_zero_mask();
    test_abort();
    test_cen_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
